// File: rtl/tia_video_sync_decoder_if.sv
// tia_video_sync_decoder_if: TIA composite video input and recovered timing outputs
interface tia_video_sync_decoder_if;
  logic       syn;
  logic       blank;
  logic [2:0] lum;
  logic [3:0] col;
  logic [7:0] hpos;
  logic [8:0] vpos;
  logic       line_start;
  logic       frame_start;
  logic       locked;
  logic       pixel_valid;
  logic [2:0] pix_lum;
  logic [3:0] pix_col;
  logic       sync_err;
  logic       vpos_ovf;
  modport master (
    output syn, blank, lum, col,
    input  hpos, vpos, line_start, frame_start, locked, pixel_valid, pix_lum, pix_col, sync_err, vpos_ovf
  );
  modport slave (
    input  syn, blank, lum, col,
    output hpos, vpos, line_start, frame_start, locked, pixel_valid, pix_lum, pix_col, sync_err, vpos_ovf
  );
endinterface

// File: rtl/tia_video_sync_decoder.sv
// tia_video_sync_decoder: recovers hpos/vpos, line/frame strobes and horizontal lock from TIA sync
module tia_video_sync_decoder #(
  parameter int LINE_CLOCKS = 228,
  parameter int HSYNC_MAX   = 32,
  parameter int VSYNC_MIN   = 128,
  parameter int MAX_LINES   = 312,
  parameter int LOCK_LINES  = 4
) (
  input logic clk,
  input logic r,
  tia_video_sync_decoder_if.slave vid
);
  typedef enum logic {S_HUNT, S_LOCKED} state_t;
  state_t     r_state;
  logic [2:0] r_good_lines;
  logic [9:0] r_sync_cnt;
  logic       r_meas;
  logic       r_vsync_seen;
  logic       r_syn_d;
  logic       w_rise, w_fall, w_wrap, w_ls, w_err, w_vs, w_unlock;
  always_comb begin
    w_rise   = vid.syn & ~r_syn_d;
    w_fall   = ~vid.syn & r_syn_d;
    w_wrap   = vid.hpos == 8'(LINE_CLOCKS - 1);
    w_ls     = w_rise | w_wrap;
    w_err    = w_fall & r_meas & (r_sync_cnt > 10'(HSYNC_MAX)) & (r_sync_cnt < 10'(VSYNC_MIN));
    w_vs     = w_fall & r_meas & (r_sync_cnt >= 10'(VSYNC_MIN));
    w_unlock = w_err | (w_rise & ~w_wrap);
  end
  assign vid.locked = r_state == S_LOCKED;
  always_ff @(posedge clk) begin
    if (r) begin
      r_state         <= S_HUNT;
      r_good_lines    <= '0;
      r_sync_cnt      <= '0;
      r_meas          <= 1'b0;
      r_vsync_seen    <= 1'b0;
      r_syn_d         <= 1'b1;
      vid.hpos        <= '0;
      vid.vpos        <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.vpos_ovf    <= 1'b0;
      vid.sync_err    <= 1'b0;
      vid.pixel_valid <= 1'b0;
      vid.pix_lum     <= '0;
      vid.pix_col     <= '0;
    end else begin
      r_syn_d         <= vid.syn;
      vid.hpos        <= w_ls ? '0 : vid.hpos + 8'd1;
      vid.line_start  <= w_ls;
      vid.frame_start <= w_ls & r_vsync_seen;
      if (w_ls) begin
        vid.vpos     <= r_vsync_seen ? '0 : (vid.vpos == 9'(MAX_LINES - 1) ? vid.vpos : vid.vpos + 9'd1);
        vid.vpos_ovf <= ~r_vsync_seen & (vid.vpos_ovf | (vid.vpos >= 9'(MAX_LINES - 2)));
      end
      r_vsync_seen <= w_vs | (r_vsync_seen & ~w_ls);
      r_meas       <= w_rise | (r_meas & ~w_fall);
      r_sync_cnt   <= w_rise ? 10'd1 : (vid.syn && r_sync_cnt != '1) ? r_sync_cnt + 10'd1 : r_sync_cnt;
      vid.sync_err <= w_err;
      // a match is a rise landing exactly on the flywheel wrap
      if (w_unlock) begin
        r_good_lines <= '0;
        r_state      <= S_HUNT;
      end else if (w_rise) begin
        r_good_lines <= r_good_lines == 3'(LOCK_LINES) ? r_good_lines : r_good_lines + 3'd1;
        if (r_good_lines >= 3'(LOCK_LINES - 1)) r_state <= S_LOCKED;
      end
      vid.pixel_valid <= vid.locked & ~vid.blank & ~vid.syn;
      vid.pix_lum     <= vid.lum;
      vid.pix_col     <= vid.col;
    end
  end
endmodule

// File: tb/tb_tia_video_sync_decoder.sv
// tb_tia_video_sync_decoder: table-driven check of sync recovery, lock, VSYNC and reset behaviour
module tb_tia_video_sync_decoder;
  logic clk = 1'b0;
  logic r;
  int   n_chk = 0;
  int   n_fail = 0;
  tia_video_sync_decoder_if vif ();
  tia_video_sync_decoder dut (.clk(clk), .r(r), .vid(vif));
  always #5 clk = ~clk;

  typedef struct {
    logic rst, syn, blank;
    logic [2:0] lum;
    logic [3:0] col;
    int n, hp, vp;
    logic ls, fs, lk, err, ovf, pv;
  } vec_t;
  vec_t q[$];

  function automatic void add(bit rst, bit syn, bit blank, int lum, int col, int n, int hp, int vp,
                              bit ls, bit fs, bit lk, bit err, bit ovf, bit pv);
    vec_t v;
    v.rst = rst; v.syn = syn; v.blank = blank; v.lum = 3'(lum); v.col = 4'(col);
    v.n = n; v.hp = hp; v.vp = vp; v.ls = ls; v.fs = fs; v.lk = lk; v.err = err; v.ovf = ovf; v.pv = pv;
    q.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_table(string tag);
    foreach (q[i]) begin
      r = q[i].rst; vif.syn = q[i].syn; vif.blank = q[i].blank; vif.lum = q[i].lum; vif.col = q[i].col;
      step(q[i].n);
      chk($sformatf("%s[%0d].hpos", tag, i), 32'(vif.hpos), 32'(q[i].hp));
      chk($sformatf("%s[%0d].vpos", tag, i), 32'(vif.vpos), 32'(q[i].vp));
      chk($sformatf("%s[%0d].line_start", tag, i), 32'(vif.line_start), 32'(q[i].ls));
      chk($sformatf("%s[%0d].frame_start", tag, i), 32'(vif.frame_start), 32'(q[i].fs));
      chk($sformatf("%s[%0d].locked", tag, i), 32'(vif.locked), 32'(q[i].lk));
      chk($sformatf("%s[%0d].sync_err", tag, i), 32'(vif.sync_err), 32'(q[i].err));
      chk($sformatf("%s[%0d].vpos_ovf", tag, i), 32'(vif.vpos_ovf), 32'(q[i].ovf));
      chk($sformatf("%s[%0d].pixel_valid", tag, i), 32'(vif.pixel_valid), 32'(q[i].pv));
      chk($sformatf("%s[%0d].pix_lum", tag, i), 32'(vif.pix_lum), q[i].rst ? 32'd0 : 32'(q[i].lum));
      chk($sformatf("%s[%0d].pix_col", tag, i), 32'(vif.pix_col), q[i].rst ? 32'd0 : 32'(q[i].col));
    end
    q.delete();
  endtask

  initial begin
    int fs_seen, err_seen;
    r = 1'b1; vif.syn = 1'b0; vif.blank = 1'b1; vif.lum = '0; vif.col = '0;
    // reset, then six 16-clk HSYNC pulses every 228 clks; lock arrives on the 5th rise
    add(1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10, 10, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      add(0, 1, 0, 1, 2, 1, 0, k, 1, 0, k >= 5, 0, 0, 0);
      add(0, 1, 0, 3, 4, 15, 15, k, 0, 0, k >= 5, 0, 0, 0);
      add(0, 0, 0, 5, 9, 212, 227, k, 0, 0, k >= 5, 0, 0, k >= 5);
    end
    run_table("lock");

    // full-line sweep: hpos walks 0..227 with line_start only at 0
    vif.syn = 1'b1; step(1);
    chk("sweep.hpos0", 32'(vif.hpos), 0);
    chk("sweep.ls0", 32'(vif.line_start), 1);
    chk("sweep.vpos0", 32'(vif.vpos), 7);
    for (int i = 1; i < 228; i++) begin
      vif.syn = i < 16; step(1);
      chk($sformatf("sweep.hpos%0d", i), 32'(vif.hpos), 32'(i));
      chk($sformatf("sweep.ls%0d", i), 32'(vif.line_start), 0);
    end
    vif.syn = 1'b1; step(1);
    chk("sweep.wrap_hpos", 32'(vif.hpos), 0);
    chk("sweep.wrap_ls", 32'(vif.line_start), 1);
    chk("sweep.wrap_vpos", 32'(vif.vpos), 8);
    chk("sweep.wrap_locked", 32'(vif.locked), 1);

    // 684-clk VSYNC started at that line start, then flywheel into a new frame
    add(0, 1, 0, 0, 0, 227, 227, 8, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 9, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 227, 227, 9, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 10, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 227, 227, 10, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 2, 3, 1, 0, 11, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 2, 3, 227, 227, 11, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 4, 6, 1, 0, 0, 1, 1, 1, 0, 0, 1);
    // stray rise at hpos 100 drops lock; four matched lines relock
    add(0, 0, 0, 0, 0, 100, 100, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 15, 15, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 212, 227, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(0, 1, 0, 0, 0, 1, 0, 1 + k, 1, 0, k == 4, 0, 0, 0);
      add(0, 1, 0, 0, 0, 15, 15, 1 + k, 0, 0, k == 4, 0, 0, 0);
      add(0, 0, 0, 7, 7, 212, 227, 1 + k, 0, 0, k == 4, 0, 0, k == 4);
    end
    // width 60 is an error, width 32 is a legal HSYNC
    add(0, 1, 0, 0, 0, 1, 0, 6, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 59, 59, 6, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 7, 1, 1, 60, 6, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 61, 6, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 166, 227, 6, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 31, 31, 7, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32, 7, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 195, 227, 7, 0, 0, 0, 0, 0, 0);
    // flywheel to vpos saturation, then a VSYNC clears the overflow flag
    add(0, 0, 0, 0, 0, 1 + 228 * 302, 0, 310, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 228, 0, 311, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 228, 0, 311, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 311, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 199, 199, 311, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 200, 311, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 27, 227, 311, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    run_table("frame");

    // reset in the middle of a VSYNC discards it
    vif.syn = 1'b1; step(1);
    chk("rst.rise_vpos", 32'(vif.vpos), 1);
    step(199);
    vif.lum = 3'd5; vif.col = 4'd9; r = 1'b1; step(1);
    chk("rst.hpos", 32'(vif.hpos), 0);
    chk("rst.vpos", 32'(vif.vpos), 0);
    chk("rst.locked", 32'(vif.locked), 0);
    chk("rst.pix_lum", 32'(vif.pix_lum), 0);
    chk("rst.pix_col", 32'(vif.pix_col), 0);
    r = 1'b0; step(5);
    chk("rst.hpos5", 32'(vif.hpos), 5);
    chk("rst.no_ls", 32'(vif.line_start), 0);
    vif.syn = 1'b0; vif.blank = 1'b1;
    fs_seen = 0; err_seen = 0;
    for (int i = 0; i < 222; i++) begin
      step(1);
      fs_seen |= int'(vif.frame_start);
      err_seen |= int'(vif.sync_err);
    end
    chk("rst.hpos227", 32'(vif.hpos), 227);
    chk("rst.pix_lum5", 32'(vif.pix_lum), 5);
    chk("rst.pix_col9", 32'(vif.pix_col), 9);
    step(1);
    chk("rst.ls", 32'(vif.line_start), 1);
    chk("rst.vpos1", 32'(vif.vpos), 1);
    chk("rst.fs", 32'(vif.frame_start), 0);
    chk("rst.fs_seen", 32'(fs_seen), 0);
    chk("rst.err_seen", 32'(err_seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
